// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches single-cycle event strobes into HIGH_CYC-cycle
// level pulses separated by at least GAP_CYC low cycles.
// Build option: define PULSE_STRETCH_QUEUE_EN to queue up to three events
// that arrive while busy; otherwise such events are dropped and flagged.
module pulse_stretch #(
  parameter int unsigned HIGH_CYC = 4,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse_in,
  output logic       level_out,
  output logic       busy,
  output logic [1:0] pend_cnt,
  output logic       drop_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [7:0] HIGH_LD = 8'(HIGH_CYC - 1);
  localparam logic [7:0] GAP_LD  = (GAP_CYC == 0) ? 8'd0 : 8'(GAP_CYC - 1);

  logic [1:0] state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       drop_nx;
  logic       last;
  logic       take;
  logic [1:0] pend_q;

`ifdef PULSE_STRETCH_QUEUE_EN
  logic [1:0] pend_nx;
`else
  assign pend_q = '0;
`endif

  // Next-state, counter, queue and drop decisions.
  // A strobe on the final busy cycle is folded into the handoff decision
  // (served directly) instead of being counted as a busy arrival.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    drop_nx  = 1'b0;
    last     = 1'b0;
    take     = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
    pend_nx  = pend_q;
`endif
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_nx = HIGH;
          cnt_nx   = HIGH_LD;
        end
      end
      HIGH: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 8'd1;
          take   = pulse_in;
        end else if (GAP_CYC != 0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LD;
          take     = pulse_in;
        end else begin
          last = 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 8'd1;
          take   = pulse_in;
        end else begin
          last = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    if (take) begin
`ifdef PULSE_STRETCH_QUEUE_EN
      if (pend_q == 2'd3) drop_nx = 1'b1;
      else                pend_nx = pend_q + 2'd1;
`else
      drop_nx = 1'b1;
`endif
    end

    if (last) begin
      if ((pend_q != '0) || pulse_in) begin
        state_nx = HIGH;
        cnt_nx   = HIGH_LD;
`ifdef PULSE_STRETCH_QUEUE_EN
        // dequeue one and enqueue the coincident strobe: net zero change
        if ((pend_q != '0) && !pulse_in) pend_nx = pend_q - 2'd1;
`endif
      end else begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      level_out <= (state_nx == HIGH);
      drop_err  <= drop_nx;
    end
  end

`ifdef PULSE_STRETCH_QUEUE_EN
  // Pending-event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_nx;
  end
`endif

  assign busy     = (state != IDLE);
  assign pend_cnt = pend_q;

endmodule
